// File: rtl/cavlc_fsm.sv
// cavlc_fsm: sequencing controller for the CAVLC residual-block decoder.
// Walks one residual block through total_coeffs, trailing-one flags, levels,
// total_zeros and run_befores, driving a one-hot state vector that selects the
// active length decoder. Tracks coefficient index and zeros-left, and pulses
// o_cavlc_valid for one enabled cycle when the block is finished.
// Optional feature macro: CAVLC_ERR_CHECK_EN enables bitstream consistency
// checks (sticky o_cavlc_err); without it o_cavlc_err is tied low and the
// zeros-left subtraction simply wraps.
module cavlc_fsm (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ena,
  input  logic       i_start,
  input  logic [4:0] i_max_coeff_num,
  input  logic [4:0] i_TotalCoeff_comb,
  input  logic [1:0] i_TrailingOnes_comb,
  input  logic [3:0] i_level_suffix_len_comb,
  input  logic [3:0] i_TotalZeros_comb,
  input  logic [3:0] i_run_before_comb,
  output logic [7:0] o_cavlc_state,
  output logic [3:0] o_i,
  output logic [4:0] o_TotalCoeff,
  output logic [1:0] o_TrailingOnes,
  output logic [3:0] o_zeros_left,
  output logic       o_cavlc_valid,
  output logic       o_cavlc_err
);

  // One-hot encoding: the state register itself is the output vector.
  typedef enum logic [7:0] {
    ST_IDLE = 8'b0000_0001,
    ST_RTC  = 8'b0000_0010,
    ST_T1S  = 8'b0000_0100,
    ST_PRE  = 8'b0000_1000,
    ST_SUF  = 8'b0001_0000,
    ST_CALC = 8'b0010_0000,
    ST_TZ   = 8'b0100_0000,
    ST_RUN  = 8'b1000_0000
  } state_t;

  state_t     r_state;
  logic [3:0] r_i;
  logic [4:0] r_total_coeff;
  logic [1:0] r_trailing_ones;
  logic [3:0] r_zeros_left;
  logic       r_valid;

  // Index seeds: TotalCoeff-1 truncated to 4 bits (16 -> 15).
  logic [3:0] w_tcc_m1;
  logic [3:0] w_tc_m1;
  // Zeros left after consuming the current run (wraps modulo 16).
  logic [3:0] w_run_z;
  // Level phase exits straight to done when the block is completely full.
  logic       w_exit_full;
  state_t     w_exit_state;
  // All coefficients were trailing ones: no level to decode.
  logic       w_t1_only;

  assign w_tcc_m1     = i_TotalCoeff_comb[3:0] - 4'd1;
  assign w_tc_m1      = r_total_coeff[3:0] - 4'd1;
  assign w_run_z      = r_zeros_left - i_run_before_comb;
  assign w_exit_full  = (r_total_coeff == i_max_coeff_num);
  assign w_exit_state = w_exit_full ? ST_IDLE : ST_TZ;
  assign w_t1_only    = (r_total_coeff == {3'b000, r_trailing_ones});

`ifdef CAVLC_ERR_CHECK_EN
  logic       r_err;
  logic       w_run_over;
  logic       w_tz_over;
  assign w_run_over = (i_run_before_comb > r_zeros_left);
  assign w_tz_over  = (({2'b00, i_TotalZeros_comb} + {1'b0, r_total_coeff}) > {1'b0, i_max_coeff_num});
  assign o_cavlc_err = r_err;
`else
  assign o_cavlc_err = 1'b0;
`endif

  assign o_cavlc_state  = r_state;
  assign o_i            = r_i;
  assign o_TotalCoeff   = r_total_coeff;
  assign o_TrailingOnes = r_trailing_ones;
  assign o_zeros_left   = r_zeros_left;
  assign o_cavlc_valid  = r_valid;

  // Block sequencer: state, index/count registers and the done pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_i             <= 4'd0;
      r_total_coeff   <= 5'd0;
      r_trailing_ones <= 2'd0;
      r_zeros_left    <= 4'd0;
      r_valid         <= 1'b0;
`ifdef CAVLC_ERR_CHECK_EN
      r_err           <= 1'b0;
`endif
    end else if (i_ena) begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_RTC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RTC: begin
          r_total_coeff   <= i_TotalCoeff_comb;
          r_trailing_ones <= i_TrailingOnes_comb;
          r_i             <= w_tcc_m1;
          if (i_TotalCoeff_comb == 5'd0) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b1;
          end else if (i_TrailingOnes_comb != 2'd0) begin
            r_state <= ST_T1S;
          end else begin
            r_state <= ST_PRE;
          end
        end
        ST_T1S: begin
          r_i <= r_i - {2'b00, r_trailing_ones};
          if (w_t1_only) begin
            r_state <= w_exit_state;
            r_valid <= w_exit_full;
            if (w_exit_full) begin
              r_zeros_left <= 4'd0;
            end
          end else begin
            r_state <= ST_PRE;
          end
        end
        ST_PRE: begin
          if (i_level_suffix_len_comb == 4'd0) begin
            r_state <= ST_CALC;
          end else begin
            r_state <= ST_SUF;
          end
        end
        ST_SUF: begin
          r_state <= ST_CALC;
        end
        ST_CALC: begin
          if (r_i == 4'd0) begin
            r_state <= w_exit_state;
            r_valid <= w_exit_full;
            if (w_exit_full) begin
              r_zeros_left <= 4'd0;
            end
          end else begin
            r_i     <= r_i - 4'd1;
            r_state <= ST_PRE;
          end
        end
        ST_TZ: begin
          r_zeros_left <= i_TotalZeros_comb;
          r_i          <= w_tc_m1;
`ifdef CAVLC_ERR_CHECK_EN
          if (w_tz_over) begin
            r_err <= 1'b1;
          end
`endif
          if ((i_TotalZeros_comb == 4'd0) || (r_total_coeff == 5'd1)) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b1;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_i <= r_i - 4'd1;
`ifdef CAVLC_ERR_CHECK_EN
          if (w_run_over) begin
            r_zeros_left <= 4'd0;
            r_err        <= 1'b1;
            r_state      <= ST_IDLE;
            r_valid      <= 1'b1;
          end else
`endif
          begin
            r_zeros_left <= w_run_z;
            if ((r_i == 4'd1) || (w_run_z == 4'd0)) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cavlc_fsm.sv
// Self-checking bench for cavlc_fsm. Each block is described at transaction
// level (counts, suffix lengths, runs); a plan of per-cycle inputs and expected
// outputs is derived from those, then replayed with random stalls while one
// compare process checks every cycle.
module tb_cavlc_fsm;

  localparam logic [7:0] S_IDLE = 8'h01;
  localparam logic [7:0] S_RTC  = 8'h02;
  localparam logic [7:0] S_T1S  = 8'h04;
  localparam logic [7:0] S_PRE  = 8'h08;
  localparam logic [7:0] S_SUF  = 8'h10;
  localparam logic [7:0] S_CALC = 8'h20;
  localparam logic [7:0] S_TZ   = 8'h40;
  localparam logic [7:0] S_RUN  = 8'h80;

  logic       clk = 1'b0;
  logic       rst, ena, start;
  logic [4:0] mx, tcc;
  logic [1:0] t1c;
  logic [3:0] slc, tzc, rbc;
  logic [7:0] o_state;
  logic [3:0] o_i, o_zl;
  logic [4:0] o_tc;
  logic [1:0] o_t1;
  logic       o_valid, o_err;

  cavlc_fsm dut (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_start(start),
    .i_max_coeff_num(mx), .i_TotalCoeff_comb(tcc), .i_TrailingOnes_comb(t1c),
    .i_level_suffix_len_comb(slc), .i_TotalZeros_comb(tzc), .i_run_before_comb(rbc),
    .o_cavlc_state(o_state), .o_i(o_i), .o_TotalCoeff(o_tc), .o_TrailingOnes(o_t1),
    .o_zeros_left(o_zl), .o_cavlc_valid(o_valid), .o_cavlc_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ena, start;
    logic [4:0] mx, tcc;
    logic [1:0] t1c;
    logic [3:0] slc, tzc, rbc;
    logic [7:0] st;
    logic [3:0] i;
    logic [4:0] tc;
    logic [1:0] t1;
    logic [3:0] zl;
    logic       v, err;
  } step_t;

  step_t plan[$];
  int    g_sl[$];
  int    g_run[$];
  int    g_mx;

  // model of the architectural registers
  logic [3:0] m_i, m_zl;
  logic [4:0] m_tc;
  logic [1:0] m_t1;
  logic       m_err;

  // expected outputs after the most recent enabled edge
  logic [7:0] e_st;
  logic [3:0] e_i, e_zl;
  logic [4:0] e_tc;
  logic [1:0] e_t1;
  logic       e_v, e_err;
  logic       chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", o_state, e_st);
      chk("onehot", $onehot(o_state), 1);
      chk("i", o_i, e_i);
      chk("TotalCoeff", o_tc, e_tc);
      chk("TrailingOnes", o_t1, e_t1);
      chk("zeros_left", o_zl, e_zl);
      chk("valid", o_valid, e_v);
      chk("err", o_err, e_err);
    end
  end

  function automatic step_t rnd_step();
    step_t s;
    s.ena = 1'b1; s.start = 1'($urandom); s.mx = 5'(g_mx);
    s.tcc = 5'($urandom); s.t1c = 2'($urandom); s.slc = 4'($urandom);
    s.tzc = 4'($urandom); s.rbc = 4'($urandom);
    s.st = 8'h00; s.i = 4'd0; s.tc = 5'd0; s.t1 = 2'd0; s.zl = 4'd0;
    s.v = 1'b0; s.err = 1'b0;
    return s;
  endfunction

  function automatic void commit(input step_t s_in, input logic [7:0] st, input logic v);
    step_t s;
    s = s_in;
    s.st = st; s.i = m_i; s.tc = m_tc; s.t1 = m_t1; s.zl = m_zl;
    s.v = v; s.err = m_err;
    plan.push_back(s);
  endfunction

  function automatic void gen_idle();
    step_t s;
    s = rnd_step();
    s.start = 1'b0;
    commit(s, S_IDLE, 1'b0);
  endfunction

  // Expand one block (counts + g_sl suffix lengths + g_run runs) into cycles.
  function automatic void gen_block(input int tc, input int t1, input int mxv, input int tz);
    step_t s;
    int nlev;
    g_mx = mxv;
    s = rnd_step();
    s.start = 1'b1;
    commit(s, S_RTC, 1'b0);
    s = rnd_step();
    s.tcc = 5'(tc); s.t1c = 2'(t1);
    m_tc = 5'(tc); m_t1 = 2'(t1); m_i = 4'(tc - 1);
    if (tc == 0) begin
      commit(s, S_IDLE, 1'b1);
      return;
    end
    nlev = tc - t1;
    if (t1 > 0) begin
      commit(s, S_T1S, 1'b0);
      s = rnd_step();
      m_i = 4'(m_i - t1);
    end
    for (int lv = 0; lv < nlev; lv++) begin
      commit(s, S_PRE, 1'b0);
      s = rnd_step();
      s.slc = 4'(g_sl[lv]);
      if (g_sl[lv] != 0) begin
        commit(s, S_SUF, 1'b0);
        s = rnd_step();
      end
      commit(s, S_CALC, 1'b0);
      s = rnd_step();
      if (lv != nlev - 1) m_i = 4'(m_i - 1);
    end
    if (tc == mxv) begin
      m_zl = 4'd0;
      commit(s, S_IDLE, 1'b1);
      return;
    end
    commit(s, S_TZ, 1'b0);
    s = rnd_step();
    s.tzc = 4'(tz);
    m_zl = 4'(tz);
    m_i = 4'(tc - 1);
`ifdef CAVLC_ERR_CHECK_EN
    if (tz + tc > mxv) m_err = 1'b1;
`endif
    if (tz == 0 || tc == 1) begin
      commit(s, S_IDLE, 1'b1);
      return;
    end
    commit(s, S_RUN, 1'b0);
    for (int r = 0; r < 32; r++) begin
      int rb;
      int old_i;
      logic [3:0] z;
      s = rnd_step();
      rb = (r < g_run.size()) ? g_run[r] : 0;
      s.rbc = 4'(rb);
      old_i = int'(m_i);
      m_i = 4'(m_i - 1);
`ifdef CAVLC_ERR_CHECK_EN
      if (rb > int'(m_zl)) begin
        m_zl = 4'd0;
        m_err = 1'b1;
        commit(s, S_IDLE, 1'b1);
        return;
      end
`endif
      z = 4'(m_zl - rb);
      m_zl = z;
      if (old_i == 1 || z == 4'd0) begin
        commit(s, S_IDLE, 1'b1);
        return;
      end
      commit(s, S_RUN, 1'b0);
    end
  endfunction

  task automatic apply(input step_t s);
    ena = s.ena; start = s.start; mx = s.mx; tcc = s.tcc; t1c = s.t1c;
    slc = s.slc; tzc = s.tzc; rbc = s.rbc;
    @(posedge clk);
    #1;
    if (s.ena) begin
      e_st = s.st; e_i = s.i; e_tc = s.tc; e_t1 = s.t1; e_zl = s.zl;
      e_v = s.v; e_err = s.err;
    end
  endtask

  task automatic run_plan(input int from, input int to, input int stall_pct, input int force_idx);
    for (int k = from; k < to; k++) begin
      int ns;
      ns = 0;
      if (k == force_idx) ns = 4;
      else if (int'($urandom_range(0, 99)) < stall_pct) ns = int'($urandom_range(1, 3));
      for (int n = 0; n < ns; n++) begin
        step_t z;
        z = rnd_step();
        z.ena = 1'b0;
        apply(z);
      end
      apply(plan[k]);
    end
  endtask

  task automatic model_reset();
    m_i = 4'd0; m_zl = 4'd0; m_tc = 5'd0; m_t1 = 2'd0; m_err = 1'b0;
    e_st = S_IDLE; e_i = 4'd0; e_tc = 5'd0; e_t1 = 2'd0; e_zl = 4'd0;
    e_v = 1'b0; e_err = 1'b0;
  endtask

  initial begin
    int n1;
    rst = 1'b1; ena = 1'b0; start = 1'b0; mx = 5'd16; tcc = 5'd0; t1c = 2'd0;
    slc = 4'd0; tzc = 4'd0; rbc = 4'd0; g_mx = 16;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_state", o_state, 8'h01);
    chk("reset_i", o_i, 0);
    chk("reset_zl", o_zl, 0);
    chk("reset_valid", o_valid, 0);
    chk_en = 1'b1;

    // zero-coefficient block
    plan.delete(); g_sl.delete(); g_run.delete();
    gen_block(0, 0, 16, 0);
    chk("zc_steps", plan.size(), 2);
    run_plan(0, plan.size(), 0, -1);
    chk("zc_state", o_state, 8'h01);
    chk("zc_valid", o_valid, 1);

    // trailing ones only
    plan.delete(); g_run = '{1, 1};
    gen_block(3, 3, 16, 2);
    chk("t1_steps", plan.size(), 6);
    run_plan(0, plan.size(), 0, -1);
    chk("t1_zl", o_zl, 0);
    chk("t1_i", o_i, 0);
    chk("t1_valid", o_valid, 1);

    // full block, no total_zeros
    plan.delete(); g_sl.delete();
    for (int k = 0; k < 16; k++) g_sl.push_back(0);
    gen_block(16, 0, 16, 5);
    chk("full_steps", plan.size(), 34);
    run_plan(0, plan.size(), 0, -1);
    chk("full_i", o_i, 0);
    chk("full_tc", o_tc, 16);
    chk("full_zl", o_zl, 0);

    // suffix with a 4-cycle stall inside read_level_suffix
    plan.delete(); g_sl = '{3, 0}; g_run = '{1};
    gen_block(2, 0, 16, 1);
    run_plan(0, plan.size(), 0, 3);
    chk("suf_zl", o_zl, 0);
    chk("suf_i", o_i, 0);

    // run_before larger than zeros_left
    plan.delete(); g_sl = '{0, 0, 0, 0}; g_run = '{5, 1};
    gen_block(4, 0, 16, 3);
    run_plan(0, 12, 0, -1);
`ifdef CAVLC_ERR_CHECK_EN
    chk("err_flag", o_err, 1);
    chk("err_zl", o_zl, 0);
    chk("err_state", o_state, 8'h01);
`else
    chk("wrap_zl", o_zl, 14);
    chk("wrap_state", o_state, 8'h80);
    chk("wrap_i", o_i, 2);
`endif
    run_plan(12, plan.size(), 0, -1);

    // reset in the middle of a block
    plan.delete(); g_sl = '{0, 0};
    gen_block(2, 0, 16, 0);
    run_plan(0, 2, 0, -1);
    chk("mid_state", o_state, 8'h08);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_state", o_state, 8'h01);
    chk("rst_i", o_i, 0);
    chk("rst_tc", o_tc, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // back-to-back blocks: start in the valid cycle
    plan.delete();
    gen_block(1, 1, 4, 2);
    n1 = plan.size();
    gen_block(0, 0, 16, 0);
    run_plan(0, n1, 0, -1);
    chk("b2b_valid", o_valid, 1);
    run_plan(n1, n1 + 1, 0, -1);
    chk("b2b_state", o_state, 8'h02);
    chk("b2b_valid_clr", o_valid, 0);
    run_plan(n1 + 1, plan.size(), 0, -1);

    // randomized blocks with idle gaps and stalls
    for (int b = 0; b < 150; b++) begin
      int mxv, tc, t1, tz, gaps, sel;
      sel = int'($urandom_range(0, 2));
      mxv = (sel == 0) ? 4 : ((sel == 1) ? 15 : 16);
      tc = int'($urandom_range(0, mxv));
      t1 = int'($urandom_range(0, (tc < 3) ? tc : 3));
      tz = int'($urandom_range(0, 15));
      g_sl.delete(); g_run.delete();
      for (int k = 0; k < 16; k++) begin
        g_sl.push_back(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 15)));
        g_run.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3)));
      end
      plan.delete();
      gaps = int'($urandom_range(0, 2));
      for (int k = 0; k < gaps; k++) gen_idle();
      gen_block(tc, t1, mxv, tz);
      run_plan(0, plan.size(), 15, -1);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
